mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative multiply/divide unit with private HI/LO registers. It sits beside the EX stage of the five-stage pipeline and executes MULT, MULTU, DIV and DIVU from forwarded rs/rt operands. It also services MTHI/MTLO writes and presents HI/LO to the EX result mux for MFHI/MFLO. While an operation runs, `busy` feeds the hazard unit so that a dependent MFHI/MFLO, or a second multiply/divide, stalls in ID.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width; only 32 is supported.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch an operation; sampled only in IDLE.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rs_val`  in  32  multiplicand or dividend.
- `rt_val`  in  32  multiplier or divisor.
- `hi_we`  in  1  MTHI write strobe.
- `lo_we`  in  1  MTLO write strobe.
- `wdata`  in  32  MTHI/MTLO data.
- `busy`  out  1  operation in progress; hazard unit stall request.
- `done`  out  1  one-cycle pulse when HI/LO are committed.
- `hi`  out  32  architectural HI.
- `lo`  out  32  architectural LO.

## Operation
- States:
  - IDLE: waits for `start`.
  - MUL: shift-add iteration.
  - DIV: restoring shift-subtract iteration.
  - FIX: sign correction and HI/LO commit.
- Transitions:
  - IDLE→MUL on `start` with op[1]=0.
  - IDLE→DIV on `start` with op[1]=1.
  - MUL or DIV→FIX when the 5-bit counter reaches 31.
  - FIX→IDLE unconditionally.
- Operand capture in IDLE on `start`:
  - Signed ops (op[0]=0): store |rs|, |rt| and the sign flags.
  - Unsigned ops: store rs, rt unchanged.
- Working registers are a 64-bit accumulator/remainder and a 32-bit multiplier/quotient. They are separate from the architectural `hi`/`lo`.
- `hi`/`lo` change only in FIX or on MTHI/MTLO. During an operation they keep their pre-operation values.
- FIX for multiply: if sign(rs)≠sign(rt), negate the 64-bit product. Then HI=product[63:32], LO=product[31:0].
- FIX for divide: negate the quotient if the signs differ; the remainder takes the sign of rs. LO=quotient, HI=remainder.
- Divide by zero: skip the correction; LO=32'hFFFF_FFFF, HI=rs_val as captured (raw, not absolute value).
- Signed 0x8000_0000 / −1 yields LO=0x8000_0000, HI=0 (natural two's-complement wrap).
- `start` while busy is ignored.
- `hi_we` or `lo_we` while busy aborts the operation:
  - state returns to IDLE, `done` is not pulsed;
  - the addressed register takes `wdata`;
  - the other register keeps its pre-operation value.
- `hi_we`/`lo_we` asserted together with `start` in IDLE: the write is performed and `start` is ignored.
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE, counter 0. Reset asserted mid-operation aborts it immediately.

## Timing
- Edge E0 samples `start`; `busy`=1 from E0 onward.
- Iterations run on edges E1..E32.
- FIX commits on E33. After E33: `busy`=0, `done`=1 for exactly one cycle, `hi`/`lo` valid.
- Latency is 33 cycles from the start edge. A new `start` is accepted in the cycle where `done`=1.
- MTHI/MTLO in IDLE update the register at the same edge; the value is visible in the next cycle.
- `busy` and `done` are registered outputs with no combinational path from any input.

## Configuration
- `MDU_FAST_MUL_EN` defined:
  - MULT/MULTU use a single-cycle 32×32 product.
  - E0 captures the operands; E1 commits HI/LO, then `busy`=0 and `done`=1.
  - The MUL state is skipped (IDLE→FIX).
  - DIV timing is unchanged.
- `MDU_FAST_MUL_EN` undefined: the iterative 33-cycle multiply described above; no hardware multiplier is inferred.

## Test plan
- MULT rs=0xFFFF_FFFD, rt=7 → after 33 cycles HI=0xFFFF_FFFF, LO=0xFFFF_FFEB; `done` high for one cycle.
- MULTU rs=rt=0xFFFF_FFFF → HI=0xFFFF_FFFE, LO=0x0000_0001; with `MDU_FAST_MUL_EN`, same result with `busy` high for one cycle.
- DIV rs=0xFFFF_FFF9 (−7), rt=2 → LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. Then DIV 0x8000_0000 / 0xFFFF_FFFF → LO=0x8000_0000, HI=0.
- DIVU rs=100, rt=0 → LO=0xFFFF_FFFF, HI=0x0000_0064.
- Start MULT, then at cycle 10:
  - pulse `start` → ignored;
  - at cycle 12, `hi_we` with wdata=0x1234 → `busy` falls, HI=0x1234, LO keeps its old value, no `done` pulse.
- Drive `rst`=0 at cycle 20 of a DIV → `busy`=0, HI=LO=0 asynchronously. After release, a new MULTU 3×5 gives LO=15, HI=0.

Source files
------------

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
//
// Iterative multiply/divide unit with private HI/LO registers, placed beside
// the EX stage. Executes MULT, MULTU, DIV and DIVU on forwarded rs/rt
// operands, services MTHI/MTLO writes and presents HI/LO for MFHI/MFLO.
// While an operation is in flight, busy requests a stall from the hazard unit.
//
// Multiply is a 32-step shift-add on operand magnitudes; divide is a 32-step
// restoring shift-subtract on magnitudes. A final FIX cycle applies the sign
// correction and commits HI/LO.
//
// Optional feature macro: MDU_FAST_MUL_EN
//   defined   : MULT/MULTU use a single-cycle 32x32 product (IDLE -> FIX),
//               so a multiply commits one edge after the start edge.
//   undefined : iterative 33-cycle multiply, no hardware multiplier.
//   Divide timing is identical in both builds.
//
// Parameters:
//   WIDTH   operand and HI/LO width (only 32 is supported)
//
// Ports:
//   clk     in   1      rising-edge clock
//   rst     in   1      asynchronous active-low reset
//   start   in   1      launch an operation (sampled only in IDLE)
//   op      in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_val  in   WIDTH  multiplicand / dividend
//   rt_val  in   WIDTH  multiplier / divisor
//   hi_we   in   1      MTHI write strobe (aborts a running operation)
//   lo_we   in   1      MTLO write strobe (aborts a running operation)
//   wdata   in   WIDTH  MTHI/MTLO data
//   busy    out  1      operation in progress (registered)
//   done    out  1      one-cycle pulse when HI/LO are committed (registered)
//   hi      out  WIDTH  architectural HI
//   lo      out  WIDTH  architectural LO
// ---------------------------------------------------------------------------
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t state, state_next;

  // Working registers, separate from the architectural hi/lo.
  // acc : product accumulator (multiply) or {remainder, dividend} (divide)
  // mq  : multiplier being consumed (multiply) or quotient being built (divide)
  // opb : multiplicand (multiply) or divisor (divide)
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mq;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH-1:0]   raw_rs;
  logic [4:0]         cnt;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               div_zero;

  logic               mt_write;
  logic               rs_neg;
  logic               rt_neg;
  logic [WIDTH-1:0]   rs_mag;
  logic [WIDTH-1:0]   rt_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // An MTHI/MTLO strobe wins over everything else: it aborts a running
  // operation and also suppresses a start presented in the same cycle.
  assign mt_write = hi_we | lo_we;

  // Operand magnitudes; unsigned ops pass operands through untouched.
  always_comb begin
    rs_neg = ~op[0] & rs_val[WIDTH-1];
    rt_neg = ~op[0] & rt_val[WIDTH-1];
    rs_mag = rs_neg ? -rs_val : rs_val;
    rt_mag = rt_neg ? -rt_val : rt_val;
  end

  // Datapath arithmetic for one iteration plus the FIX-cycle results.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mq[0] ? opb : '0)};
    // Upper 33 bits of the left-shifted remainder minus the divisor; the
    // borrow bit tells whether the subtraction is kept.
    div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb};

`ifdef MDU_FAST_MUL_EN
    product = {{WIDTH{1'b0}}, mq} * {{WIDTH{1'b0}}, opb};
`else
    product = acc;
`endif
    prod_signed = neg_res ? -product : product;

    fix_hi = prod_signed[2*WIDTH-1:WIDTH];
    fix_lo = prod_signed[WIDTH-1:0];
    if (is_div) begin
      if (div_zero) begin
        fix_lo = '1;
        fix_hi = raw_rs;
      end else begin
        fix_lo = neg_res ? -mq : mq;
        fix_hi = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic. The iteration phase ends on the 32nd step, i.e. the
  // step taken while the counter reads 31.
  always_comb begin
    state_next = state;
    if (mt_write) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (op[1]) begin
              state_next = DIV;
            end else begin
`ifdef MDU_FAST_MUL_EN
              state_next = FIX;
`else
              state_next = MUL;
`endif
            end
          end
        end
        MUL, DIV: begin
          if (cnt == 5'd31) state_next = FIX;
        end
        FIX:     state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Operand capture and iteration. Left running on an abort because nothing
  // reads these registers until the next start reloads them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc      <= '0;
      mq       <= '0;
      opb      <= '0;
      raw_rs   <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !mt_write) begin
            is_div   <= op[1];
            neg_res  <= rs_neg ^ rt_neg;
            neg_rem  <= rs_neg;
            div_zero <= (rt_val == '0);
            raw_rs   <= rs_val;
            opb      <= rt_mag;
            cnt      <= '0;
            if (op[1]) begin
              acc <= {{WIDTH{1'b0}}, rs_mag};
              mq  <= '0;
            end else begin
              acc <= '0;
              mq  <= rs_mag;
            end
          end
        end
        MUL: begin
          // Add the multiplicand into the top half when the current
          // multiplier bit is set, then shift the whole product right.
          acc <= {mul_sum, acc[WIDTH-1:1]};
          mq  <= mq >> 1;
          cnt <= cnt + 5'd1;
        end
        DIV: begin
          if (!div_trial[WIDTH]) begin
            acc <= {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            mq  <= {mq[WIDTH-2:0], 1'b1};
          end else begin
            acc <= {acc[2*WIDTH-2:0], 1'b0};
            mq  <= {mq[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  // Architectural HI/LO: written only by MTHI/MTLO or the FIX commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi <= '0;
      lo <= '0;
    end else if (mt_write) begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end else if (state == FIX) begin
      hi <= fix_hi;
      lo <= fix_lo;
    end
  end

  // Registered status so the hazard unit sees no input-to-output path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state == FIX) && !mt_write;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit
//
// Self-checking bench for mul_div_unit: a table of operations with expected
// HI/LO, a scoreboard queue of expected results, and hand-written sequences
// for MTHI/MTLO, abort, ignored start and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .wdata  (wdata),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  vec_t        vecs[12];
  logic [63:0] sbq[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] model_hi;
  logic [31:0] model_lo;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Drives one operation, pushes its expected result, waits for done and
  // checks latency, HI/LO hold during the operation, result and pulse width.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] eh, input logic [31:0] el);
    int          cycles;
    int          lat;
    logic [63:0] e;
    lat = 33;
`ifdef MDU_FAST_MUL_EN
    if (!o[1]) lat = 1;
`endif
    @(negedge clk);
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    sbq.push_back({eh, el});
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    checkOutput("busy_after_start", {31'b0, busy}, 32'd1);
    while (!done && cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (cycles == 5 && !done) begin
        checkOutput("hi_hold", hi, model_hi);
        checkOutput("lo_hold", lo, model_lo);
      end
    end
    e = sbq.pop_front();
    if (!done) begin
      checkOutput("done_timeout", 32'd0, 32'd1);
    end else begin
      checkOutput("latency", 32'(cycles), 32'(lat));
      checkOutput("hi", hi, e[63:32]);
      checkOutput("lo", lo, e[31:0]);
      checkOutput("busy_at_done", {31'b0, busy}, 32'd0);
    end
    model_hi = e[63:32];
    model_lo = e[31:0];
    @(negedge clk);
    checkOutput("done_width", {31'b0, done}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int         cycles;
    int         done_cnt;
    logic [1:0] abort_op;

    vecs[0]  = '{OP_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[4]  = '{OP_DIVU,  32'd100,       32'd0,        32'h0000_0064, 32'hFFFF_FFFF};
    vecs[5]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[6]  = '{OP_MULT,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
    vecs[7]  = '{OP_DIVU,  32'hFFFF_FFFF, 32'd10,       32'h0000_0005, 32'h1999_9999};
    vecs[8]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[9]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[10] = '{OP_MULTU, 32'd3,         32'd5,        32'h0000_0000, 32'h0000_000F};
    vecs[11] = '{OP_DIV,   32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002};

    rst = 1'b0; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    model_hi = '0; model_lo = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("reset_hi", hi, 32'd0);
    checkOutput("reset_lo", lo, 32'd0);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_done", {31'b0, done}, 32'd0);

    for (int i = 0; i < 12; i++)
      applyStimulus(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].exp_hi, vecs[i].exp_lo);

    // MTLO / MTHI in IDLE
    @(negedge clk);
    lo_we = 1'b1; wdata = 32'h5555_AAAA;
    @(negedge clk);
    lo_we = 1'b0;
    model_lo = 32'h5555_AAAA;
    checkOutput("mtlo", lo, model_lo);
    checkOutput("mtlo_hi_kept", hi, model_hi);
    hi_we = 1'b1; wdata = 32'hCAFE_F00D;
    @(negedge clk);
    hi_we = 1'b0;
    model_hi = 32'hCAFE_F00D;
    checkOutput("mthi", hi, model_hi);

    // MTHI together with start: the write wins, start is dropped
    hi_we = 1'b1; wdata = 32'h0BAD_BEEF; start = 1'b1; op = OP_MULTU; rs_val = 32'd3; rt_val = 32'd5;
    @(negedge clk);
    hi_we = 1'b0; start = 1'b0;
    model_hi = 32'h0BAD_BEEF;
    checkOutput("mthi_start_busy", {31'b0, busy}, 32'd0);
    checkOutput("mthi_start_hi", hi, model_hi);
    checkOutput("mthi_start_lo", lo, model_lo);

    // Abort a running operation with MTHI; a start mid-operation is ignored
`ifdef MDU_FAST_MUL_EN
    abort_op = OP_DIVU;
`else
    abort_op = OP_MULT;
`endif
    start = 1'b1; op = abort_op; rs_val = 32'd5; rt_val = 32'd6;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    done_cnt = 0;
    while (cycles < 10) begin
      @(negedge clk);
      cycles++;
      if (done) done_cnt++;
    end
    start = 1'b1; op = OP_DIVU; rs_val = 32'd9; rt_val = 32'd3;
    @(negedge clk);
    start = 1'b0;
    checkOutput("start_ignored_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk);
    hi_we = 1'b0;
    model_hi = 32'h0000_1234;
    checkOutput("abort_busy", {31'b0, busy}, 32'd0);
    checkOutput("abort_hi", hi, model_hi);
    checkOutput("abort_lo", lo, model_lo);
    repeat (40) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    checkOutput("abort_no_done", 32'(done_cnt), 32'd0);
    checkOutput("abort_hi_after", hi, model_hi);

    // Asynchronous reset in the middle of a DIV
    start = 1'b1; op = OP_DIV; rs_val = 32'hFFFF_FF00; rt_val = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("async_rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("async_rst_hi", hi, 32'd0);
    checkOutput("async_rst_lo", lo, 32'd0);
    model_hi = '0;
    model_lo = '0;
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15);

    checkOutput("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
